// File: rtl/alarm_timer_ctrl.sv
// Alarm timing sequencer: one shared 1 s prescaler steps DISARMED/EXIT/ARMED/ENTRY/ALARM phases.
// Optional macro TAMPER_EN adds an enclosure tamper input that forces ALARM over everything else.
module alarm_timer_ctrl #(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int EXIT_S         = 30,
    parameter int ENTRY_S        = 15,
    parameter int SIREN_S        = 120,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             disarm,
    input  logic             sensor,
`ifdef TAMPER_EN
    input  logic             tamper,
`endif
    output logic [2:0]       state,
    output logic             armed,
    output logic             siren,
    output logic             beep,
    output logic [CNT_W-1:0] secs_left
);

    localparam int PRESC_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0]   SECS_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   SECS_ONE   = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_SEC - 1);

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    state_e             state_r, state_nx_s, fsm_nx_s;
    logic [CNT_W-1:0]   secs_r, secs_nx_s, fsm_secs_s;
    logic [PRESC_W-1:0] presc_r, presc_nx_s;
    logic               beep_r, beep_nx_s;
    logic               armed_r, armed_nx_s;
    logic               siren_r, siren_nx_s;
    logic               tick_s, last_s, trans_s, timed_nx_s;

    assign tick_s = (presc_r == PRESC_LAST);
    // Treating 0 like 1 means a corrupted counter expires the phase instead of wrapping.
    assign last_s = (secs_r <= SECS_ONE);

    // Phase sequencing with disarm > arm > sensor > tick priority
    always_comb begin
        fsm_nx_s   = state_r;
        fsm_secs_s = secs_r;
        case (state_r)
            ST_DISARMED: begin
                if (arm) begin
                    fsm_nx_s   = ST_EXIT;
                    fsm_secs_s = CNT_W'(EXIT_S);
                end else begin
                    fsm_secs_s = SECS_ZERO;
                end
            end
            ST_EXIT: begin
                if (disarm) begin
                    fsm_nx_s   = ST_DISARMED;
                    fsm_secs_s = SECS_ZERO;
                end else if (tick_s && last_s) begin
                    fsm_nx_s   = ST_ARMED;
                    fsm_secs_s = SECS_ZERO;
                end else if (tick_s) begin
                    fsm_secs_s = secs_r - SECS_ONE;
                end else begin
                    fsm_secs_s = secs_r;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    fsm_nx_s   = ST_DISARMED;
                    fsm_secs_s = SECS_ZERO;
                end else if (sensor) begin
                    fsm_nx_s   = ST_ENTRY;
                    fsm_secs_s = CNT_W'(ENTRY_S);
                end else begin
                    fsm_secs_s = SECS_ZERO;
                end
            end
            ST_ENTRY: begin
                if (disarm) begin
                    fsm_nx_s   = ST_DISARMED;
                    fsm_secs_s = SECS_ZERO;
                end else if (tick_s && last_s) begin
                    fsm_nx_s   = ST_ALARM;
                    fsm_secs_s = CNT_W'(SIREN_S);
                end else if (tick_s) begin
                    fsm_secs_s = secs_r - SECS_ONE;
                end else begin
                    fsm_secs_s = secs_r;
                end
            end
            ST_ALARM: begin
                if (disarm) begin
                    fsm_nx_s   = ST_DISARMED;
                    fsm_secs_s = SECS_ZERO;
                end else if (tick_s && last_s) begin
                    fsm_nx_s   = ST_ARMED;
                    fsm_secs_s = SECS_ZERO;
                end else if (tick_s) begin
                    fsm_secs_s = secs_r - SECS_ONE;
                end else begin
                    fsm_secs_s = secs_r;
                end
            end
            default: begin
                fsm_nx_s   = ST_DISARMED;
                fsm_secs_s = SECS_ZERO;
            end
        endcase

`ifdef TAMPER_EN
        if (tamper) begin
            state_nx_s = ST_ALARM;
            secs_nx_s  = CNT_W'(SIREN_S);
        end else begin
            state_nx_s = fsm_nx_s;
            secs_nx_s  = fsm_secs_s;
        end
`else
        state_nx_s = fsm_nx_s;
        secs_nx_s  = fsm_secs_s;
`endif
    end

    // Prescaler, beep and status flags derived from the chosen next state
    always_comb begin
        trans_s    = (state_nx_s != state_r);
        timed_nx_s = (state_nx_s == ST_EXIT) || (state_nx_s == ST_ENTRY);
        armed_nx_s = (state_nx_s == ST_ARMED) || (state_nx_s == ST_ENTRY) ||
                     (state_nx_s == ST_ALARM);
        siren_nx_s = (state_nx_s == ST_ALARM);

        // Restarting on each transition keeps the first second of every phase full length.
        if (trans_s || tick_s) begin
            presc_nx_s = PRESC_ZERO;
        end else begin
            presc_nx_s = presc_r + PRESC_ONE;
        end
`ifdef TAMPER_EN
        if (tamper) begin
            presc_nx_s = PRESC_ZERO;
        end else begin
            presc_nx_s = presc_nx_s;
        end
`endif

        if (!timed_nx_s || trans_s) begin
            beep_nx_s = 1'b0;
        end else if (tick_s) begin
            beep_nx_s = ~beep_r;
        end else begin
            beep_nx_s = beep_r;
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_DISARMED;
            secs_r  <= SECS_ZERO;
            presc_r <= PRESC_ZERO;
            beep_r  <= 1'b0;
            armed_r <= 1'b0;
            siren_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            secs_r  <= secs_nx_s;
            presc_r <= presc_nx_s;
            beep_r  <= beep_nx_s;
            armed_r <= armed_nx_s;
            siren_r <= siren_nx_s;
        end
    end

    assign state     = state_r;
    assign armed     = armed_r;
    assign siren     = siren_r;
    assign beep      = beep_r;
    assign secs_left = secs_r;

endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Bench for alarm_timer_ctrl: directed phase scenarios plus random traffic against an
// elapsed-cycles reference model. Tamper stimulus is included when TAMPER_EN is defined.
module tb_alarm_timer_ctrl;

    localparam int CPS     = 4;
    localparam int EXIT_S  = 2;
    localparam int ENTRY_S = 3;
    localparam int SIREN_S = 2;
    localparam int CNT_W   = 8;

    logic             clk, rst, arm, disarm, sensor, tamper;
    logic [2:0]       state;
    logic             armed, siren, beep;
    logic [CNT_W-1:0] secs_left;

    int n_chk, n_fail;
    int m_st, m_e;      // model phase and cycles elapsed since entering it
    bit siren_seen;

    alarm_timer_ctrl #(
        .CYCLES_PER_SEC(CPS), .EXIT_S(EXIT_S), .ENTRY_S(ENTRY_S),
        .SIREN_S(SIREN_S), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .sensor(sensor),
`ifdef TAMPER_EN
        .tamper(tamper),
`endif
        .state(state), .armed(armed), .siren(siren), .beep(beep), .secs_left(secs_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Phase lengths expressed as total cycles; secs_left and beep follow from elapsed time.
    task automatic model_step();
        if (rst) begin
            m_st = 0; m_e = 0;
        end else if (tamper) begin
            m_st = 4; m_e = 0;
        end else begin
            case (m_st)
                0: if (arm) begin m_st = 1; m_e = 0; end
                1: if (disarm) m_st = 0;
                   else if (m_e + 1 == EXIT_S * CPS) m_st = 2;
                   else m_e++;
                2: if (disarm) m_st = 0;
                   else if (sensor) begin m_st = 3; m_e = 0; end
                3: if (disarm) m_st = 0;
                   else if (m_e + 1 == ENTRY_S * CPS) begin m_st = 4; m_e = 0; end
                   else m_e++;
                4: if (disarm) m_st = 0;
                   else if (m_e + 1 == SIREN_S * CPS) m_st = 2;
                   else m_e++;
                default: m_st = 0;
            endcase
        end
    endtask

    function automatic int exp_secs();
        case (m_st)
            1:       return EXIT_S - m_e / CPS;
            3:       return ENTRY_S - m_e / CPS;
            4:       return SIREN_S - m_e / CPS;
            default: return 0;
        endcase
    endfunction

    task automatic step(input bit a, input bit d, input bit s, input bit r, input bit t);
        arm = a; disarm = d; sensor = s; rst = r; tamper = t;
        @(posedge clk);
        model_step();
        #1;
        chk("state", state, m_st);
        chk("armed", armed, (m_st >= 2));
        chk("siren", siren, (m_st == 4));
        chk("beep", beep, (m_st == 1 || m_st == 3) ? (m_e / CPS) % 2 : 0);
        chk("secs_left", secs_left, exp_secs());
        if (siren) siren_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_st = 0; m_e = 0; siren_seen = 1'b0;
        arm = 1'b0; disarm = 1'b0; sensor = 1'b0; rst = 1'b1; tamper = 1'b0;

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_state", state, 0);
        chk("reset_secs", secs_left, 0);

        // Arm: full 8-cycle exit delay
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("exit_secs", secs_left, 2);
        idle(8);
        chk("exit_to_armed", state, 2);

        // Sensor: 12-cycle entry delay then siren
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("entry_secs", secs_left, 3);
        idle(12);
        chk("entry_to_alarm", state, 4);
        chk("alarm_secs", secs_left, 2);

        // Siren expiry with sensor held: one ARMED cycle then fresh ENTRY
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rearm_one_cycle", state, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reentry", state, 3);
        chk("reentry_secs", secs_left, 3);

        // Disarm on the expiry cycle beats the ALARM entry
        siren_seen = 1'b0;
        idle(11);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("disarm_wins", state, 0);
        chk("no_siren", siren_seen, 0);

        // Reset mid-ALARM, then a full exit delay again
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(15);
        chk("in_alarm", state, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_alarm", state, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(7);
        chk("exit_still", state, 1);
        idle(1);
        chk("exit_done", state, 2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef TAMPER_EN
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("tamper_alarm", state, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("tamper_beats_disarm", state, 4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            bit t;
`ifdef TAMPER_EN
            t = ($urandom % 150) == 0;
`else
            t = 1'b0;
`endif
            step(($urandom % 8) == 0, ($urandom % 48) == 0, ($urandom % 6) == 0,
                 ($urandom % 400) == 0, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
